cdb_arbiter: RTL and testbench
==============================

CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 SHALL have parameter NUM_FU, default 4: number of functional-unit requesters (ALU, MUL, DIV, BR); legal values 2..8.
REQ-002 SHALL have parameter FIFO_DEPTH, default 2: entries per requester queue; legal values 2 or 4.
REQ-003 SHALL have port clk, input, 1: single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port flush, input, 1: mispredict squash; discards all buffered and in-flight results.
REQ-006 SHALL have port fu_out, input, NUM_FU x funct_unit_out_t: per-unit result; out_valid field is the request.
REQ-007 SHALL have port fu_ready, output, NUM_FU: per-unit accept; result accepted when out_valid && fu_ready.
REQ-008 SHALL have port cdb_out, output, funct_unit_out_t: registered broadcast to ROB, RAT and reservation stations.
REQ-009 SHALL have port grant, output, NUM_FU: registered one-hot source of cdb_out; all zero when cdb_out.out_valid is 0.

Function
REQ-010 SHALL keep one FIFO_DEPTH-entry queue per unit, with head/tail pointers wrapping modulo FIFO_DEPTH and a count of 0..FIFO_DEPTH.
REQ-011 SHALL drive fu_ready[i] = (count[i] < FIFO_DEPTH) from registered count only; a same-cycle dequeue SHALL NOT raise fu_ready.
REQ-012 SHALL enqueue fu_out[i] at the edge ending any cycle with fu_out[i].out_valid && fu_ready[i].
REQ-013 SHALL ignore out_valid while fu_ready[i] is 0; the unit holds its result (ALU units with ready tied 1 SHALL stall issue upstream).
REQ-014 SHALL pick at most one non-empty queue per cycle, round-robin, starting the search at rr_ptr and wrapping NUM_FU-1 -> 0.
REQ-015 SHALL set rr_ptr to (granted index + 1) mod NUM_FU after a grant, and leave rr_ptr unchanged when no queue is non-empty.
REQ-016 SHALL dequeue the granted head and register it into cdb_out and grant at the same edge; cdb_out.out_valid SHALL be 0 in any cycle after an edge with no grant.
REQ-017 SHALL have a minimum latency of 2 cycles: a result accepted in cycle N is granted in cycle N+1 at earliest and visible on cdb_out in N+2.
REQ-018 SHALL allow simultaneous enqueue and dequeue on one queue in one cycle; count is unchanged, including when count = FIFO_DEPTH.
REQ-019 SHALL ignore enqueue on a full queue and dequeue on an empty queue; counts never overflow or underflow.
REQ-020 SHALL preserve per-unit order; there is no ordering guarantee across units.
REQ-021 SHALL, on flush, clear all counts and pointers, zero cdb_out.out_valid and grant, drop same-cycle inputs, and leave rr_ptr unchanged.
REQ-022 SHALL give flush priority over enqueue and grant in the same cycle.
REQ-023 SHALL give a continuously requesting unit a grant within NUM_FU cycles of becoming queue head.

Reset
REQ-024 SHALL, on rst, set all counts and head/tail pointers to 0, rr_ptr to 0, cdb_out to all-zero, and grant to 0.
REQ-025 SHALL drive fu_ready all ones in the first cycle after rst deasserts.
REQ-026 SHALL discard queued entries when rst asserts mid-operation, with no cdb_out.out_valid in the following cycle.

Structure
REQ-027 SHALL take funct_unit_out_t from CDB_types; NUM_FU_DEFAULT and the FU index constants (FU_ALU = 0, FU_MUL = 1, FU_DIV = 2, FU_BR = 3) SHALL live in CDB_types.
REQ-028 SHALL instantiate sub-module cdb_fu_fifo (parameter FIFO_DEPTH; ports clk, rst, flush, enq, enq_data, deq, head, count) once per unit.
REQ-029 SHALL implement the round-robin picker as combinational logic in cdb_arbiter.

Verification
REQ-030 Single ALU result, rob_idx = 5, accepted in cycle 1 -> cdb_out.out_valid = 1, rob_idx = 5, grant = 4'b0001 in cycle 3 only.
REQ-031 All 4 units valid in cycle 1 with rr_ptr = 0 -> grants 0001, 0010, 0100, 1000 on cycles 3..6, then out_valid = 0.
REQ-032 MUL valid every cycle while grants go to others -> fu_ready[1] = 0 after 2 accepted entries; no loss; MUL order preserved on cdb_out.
REQ-033 flush in cycle 4 with 3 results queued -> cdb_out.out_valid = 0 in cycle 5, fu_ready all 1, none of the 3 ever broadcast.
REQ-034 rst for 1 cycle with queues full -> all outputs zero the next cycle, rr_ptr = 0, first later grant goes to the lowest-index requester.
REQ-035 Queue at count 2 with accept and grant in the same cycle -> count stays 2, fu_ready[i] stays 0, entries appear in FIFO order.

Source files
------------

// File: rtl/CDB_types.sv
// Shared types and constants for the common-data-bus arbiter: the functional-unit
// result word that travels from each unit, through its queue, onto the CDB.
package CDB_types;

  localparam int NUM_FU_DEFAULT = 4;

  localparam int FU_ALU = 0;
  localparam int FU_MUL = 1;
  localparam int FU_DIV = 2;
  localparam int FU_BR  = 3;

  localparam int ROB_IDX_W = 5;
  localparam int DATA_W    = 32;

  typedef struct packed {
    logic                 out_valid;
    logic [ROB_IDX_W-1:0] rob_idx;
    logic [DATA_W-1:0]    value;
    logic                 exception;
  } funct_unit_out_t;

endpackage

// File: rtl/cdb_fu_fifo.sv
// Per-unit result queue: FIFO_DEPTH entries, head/tail pointers and an occupancy count.
// Flush and reset empty the queue; storage contents are qualified by the count.
module cdb_fu_fifo
  import CDB_types::*;
#(
  parameter  int FIFO_DEPTH = 2,
  localparam int CNT_W      = $clog2(FIFO_DEPTH + 1),
  localparam int PTR_W      = $clog2(FIFO_DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             enq,
  input  funct_unit_out_t  enq_data,
  input  logic             deq,
  output funct_unit_out_t  head,
  output logic [CNT_W-1:0] count
);

  funct_unit_out_t  mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] head_ptr_q, head_ptr_d;
  logic [PTR_W-1:0] tail_ptr_q, tail_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             full, empty, do_enq, do_deq;

  assign full   = (count_q == CNT_W'(FIFO_DEPTH));
  assign empty  = (count_q == '0);
  assign do_deq = deq && !empty && !flush;
  // A full queue only takes a new entry when the head leaves in the same cycle.
  assign do_enq = enq && (!full || do_deq) && !flush;

  // NOTE: every signal driven here gets a default first, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    head_ptr_d = head_ptr_q;
    tail_ptr_d = tail_ptr_q;
    count_d    = count_q;
    if (flush) begin
      head_ptr_d = '0;
      tail_ptr_d = '0;
      count_d    = '0;
    end else begin
      // Depth is a power of two, so the pointer width itself wraps modulo FIFO_DEPTH.
      if (do_enq) tail_ptr_d = tail_ptr_q + PTR_W'(1);
      if (do_deq) head_ptr_d = head_ptr_q + PTR_W'(1);
      case ({do_enq, do_deq})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_ptr_q <= '0;
      tail_ptr_q <= '0;
      count_q    <= '0;
    end else begin
      head_ptr_q <= head_ptr_d;
      tail_ptr_q <= tail_ptr_d;
      count_q    <= count_d;
    end
  end

  // NOTE: the storage array is deliberately not reset; pointers and count decide which entries are live.
  always_ff @(posedge clk) begin
    if (do_enq) mem_q[tail_ptr_q] <= enq_data;
  end

  assign head  = mem_q[head_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/cdb_arbiter.sv
// Common-data-bus arbiter: buffers each functional unit's results in its own queue
// and broadcasts one per cycle, chosen round-robin, through a registered output.
module cdb_arbiter
  import CDB_types::*;
#(
  parameter  int NUM_FU     = NUM_FU_DEFAULT,
  parameter  int FIFO_DEPTH = 2,
  localparam int CNT_W      = $clog2(FIFO_DEPTH + 1),
  localparam int IDX_W      = $clog2(NUM_FU)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  funct_unit_out_t [NUM_FU-1:0] fu_out,
  output logic            [NUM_FU-1:0] fu_ready,
  output funct_unit_out_t              cdb_out,
  output logic            [NUM_FU-1:0] grant
);

  logic [CNT_W-1:0] count [NUM_FU];
  funct_unit_out_t  head  [NUM_FU];
  logic [NUM_FU-1:0] enq, deq;

  logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d;
  funct_unit_out_t   cdb_out_q, cdb_out_d;
  logic [NUM_FU-1:0] grant_q, grant_d;
  logic              pick_found;
  logic [IDX_W-1:0]  pick_idx;

  // Ready depends on registered occupancy only, so a same-cycle grant never reopens a full queue.
  always_comb begin
    for (int i = 0; i < NUM_FU; i++) begin
      fu_ready[i] = (count[i] < CNT_W'(FIFO_DEPTH));
      enq[i]      = fu_out[i].out_valid && fu_ready[i] && !flush;
    end
  end

  for (genvar g = 0; g < NUM_FU; g++) begin : g_fifo
    cdb_fu_fifo #(
      .FIFO_DEPTH(FIFO_DEPTH)
    ) u_fifo (
      .clk      (clk),
      .rst      (rst),
      .flush    (flush),
      .enq      (enq[g]),
      .enq_data (fu_out[g]),
      .deq      (deq[g]),
      .head     (head[g]),
      .count    (count[g])
    );
  end

  // Round-robin search starting at rr_ptr; the first non-empty queue wins the bus.
  always_comb begin
    grant_d    = '0;
    cdb_out_d  = '0;
    rr_ptr_d   = rr_ptr_q;
    pick_found = 1'b0;
    pick_idx   = '0;
    if (!flush) begin
      for (int k = 0; k < NUM_FU; k++) begin
        pick_idx = IDX_W'((int'(rr_ptr_q) + k) % NUM_FU);
        if (!pick_found && (count[pick_idx] != '0)) begin
          pick_found        = 1'b1;
          grant_d[pick_idx] = 1'b1;
          cdb_out_d         = head[pick_idx];
          rr_ptr_d          = (int'(pick_idx) == NUM_FU - 1) ? '0 : pick_idx + IDX_W'(1);
        end
      end
    end
    deq = grant_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q  <= '0;
      cdb_out_q <= '0;
      grant_q   <= '0;
    end else begin
      rr_ptr_q  <= rr_ptr_d;
      cdb_out_q <= cdb_out_d;
      grant_q   <= grant_d;
    end
  end

  assign cdb_out = cdb_out_q;
  assign grant   = grant_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter: accepted results go into per-unit expected queues
// and are popped when they appear on the CDB; directed checks cover timing and corner cases.
module tb_cdb_arbiter;
  import CDB_types::*;

  localparam int N = 4;

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic                   flush = 1'b0;
  funct_unit_out_t [N-1:0] fu_out;
  logic [N-1:0]           fu_ready;
  funct_unit_out_t        cdb_out;
  logic [N-1:0]           grant;

  int total = 0;
  int bad   = 0;

  funct_unit_out_t exp_q [N][$];
  logic [N-1:0]    accepted = '0;
  int              seq [N];

  cdb_arbiter #(
    .NUM_FU    (N),
    .FIFO_DEPTH(2)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .flush   (flush),
    .fu_out  (fu_out),
    .fu_ready(fu_ready),
    .cdb_out (cdb_out),
    .grant   (grant)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic funct_unit_out_t mk(input int unit, input int n);
    funct_unit_out_t r;
    r.out_valid = 1'b1;
    r.rob_idx   = ROB_IDX_W'(unit * 8 + n);
    r.value     = 32'hC0DE_0000 | 32'(unit << 12) | 32'(n);
    r.exception = ((n % 3) == 0);
    return r;
  endfunction

  function automatic int pending();
    int s = 0;
    for (int i = 0; i < N; i++) s += exp_q[i].size();
    return s;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    fu_out = '0;
  endtask

  task automatic do_reset(input int cycles);
    rst   = 1'b1;
    flush = 1'b0;
    idle();
    repeat (cycles) step();
    check("rst_cdb", 64'(cdb_out), 64'd0);
    check("rst_grant", 64'(grant), 64'd0);
    check("rst_ready", 64'(fu_ready), 64'hF);
    rst = 1'b0;
  endtask

  task automatic drain(input string tag, input int budget);
    int n = 0;
    while ((pending() != 0 || cdb_out.out_valid) && n < budget) begin
      step();
      n++;
    end
    check(tag, 64'(pending()), 64'd0);
  endtask

  // Scoreboard monitor: sampled mid-cycle, when inputs and registered outputs are stable.
  always @(negedge clk) begin
    int u;
    u = -1;
    for (int i = 0; i < N; i++) if (grant[i]) u = i;
    if (cdb_out.out_valid) begin
      check("grant_onehot", 64'($countones(grant)), 64'd1);
      if (u >= 0) begin
        check("sb_has_entry", 64'(exp_q[u].size() != 0), 64'd1);
        if (exp_q[u].size() != 0) check("cdb_word", 64'(cdb_out), 64'(exp_q[u].pop_front()));
      end
    end else begin
      check("grant_idle", 64'(grant), 64'd0);
    end
    for (int i = 0; i < N; i++)
      accepted[i] = fu_out[i].out_valid && fu_ready[i] && !flush && !rst;
    if (rst || flush) begin
      for (int i = 0; i < N; i++) exp_q[i].delete();
    end else begin
      for (int i = 0; i < N; i++) if (accepted[i]) exp_q[i].push_back(fu_out[i]);
    end
  end

  initial begin
    logic [N-1:0]    exp_g;
    funct_unit_out_t tmp;

    idle();
    do_reset(2);

    // Single ALU result: visible exactly two cycles after acceptance, for one cycle.
    fu_out[FU_ALU] = mk(FU_ALU, 5);
    step();
    idle();
    check("t1_c2_valid", 64'(cdb_out.out_valid), 64'd0);
    step();
    check("t1_c3_valid", 64'(cdb_out.out_valid), 64'd1);
    check("t1_c3_rob", 64'(cdb_out.rob_idx), 64'd5);
    check("t1_c3_grant", 64'(grant), 64'b0001);
    step();
    check("t1_c4_valid", 64'(cdb_out.out_valid), 64'd0);
    check("t1_c4_grant", 64'(grant), 64'd0);
    drain("t1_drain", 10);

    // All four units at once from rr_ptr = 0: grants rotate 0,1,2,3.
    do_reset(2);
    for (int i = 0; i < N; i++) fu_out[i] = mk(i, 10);
    step();
    idle();
    check("t2_c2_valid", 64'(cdb_out.out_valid), 64'd0);
    for (int k = 0; k < N; k++) begin
      step();
      exp_g = 4'b0001 << k;
      tmp   = mk(k, 10);
      check("t2_grant", 64'(grant), 64'(exp_g));
      check("t2_rob", 64'(cdb_out.rob_idx), 64'(tmp.rob_idx));
    end
    step();
    check("t2_after_valid", 64'(cdb_out.out_valid), 64'd0);
    drain("t2_drain", 10);

    // Every unit requests every cycle and holds its result while not ready.
    for (int i = 0; i < N; i++) seq[i] = 0;
    for (int c = 0; c < 24; c++) begin
      if (c == 0) check("t3_ready_c1", 64'(fu_ready), 64'hF);
      if (c == 2) check("t3_ready_c3", 64'(fu_ready), 64'b0001);
      if (c == 3) check("t3_ready_c4", 64'(fu_ready), 64'b0010);
      for (int i = 0; i < N; i++) fu_out[i] = mk(i, seq[i]);
      step();
      for (int i = 0; i < N; i++) if (accepted[i]) seq[i]++;
    end
    idle();
    check("t3_mul_progress", 64'(seq[FU_MUL] >= 4), 64'd1);
    drain("t3_drain", 40);

    // Flush with three results queued; a same-cycle BR result is dropped too.
    fu_out[FU_ALU] = mk(FU_ALU, 20);
    fu_out[FU_MUL] = mk(FU_MUL, 20);
    fu_out[FU_DIV] = mk(FU_DIV, 20);
    step();
    idle();
    fu_out[FU_BR] = mk(FU_BR, 21);
    flush = 1'b1;
    check("t4_pre_valid", 64'(cdb_out.out_valid), 64'd0);
    step();
    flush = 1'b0;
    idle();
    check("t4_post_valid", 64'(cdb_out.out_valid), 64'd0);
    check("t4_post_grant", 64'(grant), 64'd0);
    check("t4_post_ready", 64'(fu_ready), 64'hF);
    repeat (8) step();
    check("t4_none_broadcast", 64'(pending()), 64'd0);

    // Reset mid-operation with rr_ptr at 2: afterwards MUL must beat BR.
    do_reset(2);
    for (int i = 0; i < N; i++) seq[i] = 0;
    for (int c = 0; c < 3; c++) begin
      for (int i = 0; i < N; i++) fu_out[i] = mk(i, seq[i]);
      step();
      for (int i = 0; i < N; i++) if (accepted[i]) seq[i]++;
    end
    do_reset(1);
    fu_out[FU_MUL] = mk(FU_MUL, 9);
    fu_out[FU_BR]  = mk(FU_BR, 9);
    step();
    idle();
    check("t5_c2_valid", 64'(cdb_out.out_valid), 64'd0);
    step();
    tmp = mk(FU_MUL, 9);
    check("t5_first_grant", 64'(grant), 64'b0010);
    check("t5_first_rob", 64'(cdb_out.rob_idx), 64'(tmp.rob_idx));
    step();
    check("t5_second_grant", 64'(grant), 64'b1000);
    drain("t5_drain", 10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
